timer_dev: RTL and testbench

Memory-mapped programmable down-counter that answers CPU load/store accesses on the peripheral side of the data-memory bus. Two instances sit behind the system bridge at 0x7F00–0x7F0B and 0x7F10–0x7F1B. They supply the word returned to the MEM stage as `PrRD` and raise an interrupt request toward CP0. The MEM stage has already screened every access, including alignment, width and writes to COUNT; the block decodes only the word offset.

---
 rtl/timer_dev_pkg.sv | 41 ++++
 rtl/timer_dev.sv | 97 +++++++++
 tb/tb_timer_dev.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// Shared encodings for the memory-mapped down-counter: FSM states, register
// offsets and the CTRL register layout.
package timer_dev_pkg;

    typedef enum logic [1:0] {
        TIM_IDLE = 2'd0,
        TIM_LOAD = 2'd1,
        TIM_CNT  = 2'd2,
        TIM_INT  = 2'd3
    } tim_state_e;

    localparam logic [1:0] TIM_CTRL   = 2'd0;
    localparam logic [1:0] TIM_PRESET = 2'd1;
    localparam logic [1:0] TIM_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] TIM_MODE_RELOAD = 2'd1;

    // Packed so that im lands on bit 3, mode on 2:1 and en on bit 0.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tim_ctrl_t;

    function automatic logic [31:0] ctrl_to_word(tim_ctrl_t c);
        return {28'd0, c};
    endfunction

    function automatic tim_ctrl_t ctrl_from_word(logic [31:0] w);
        tim_ctrl_t c;
        c.en   = w[CTRL_EN_BIT];
        c.mode = w[CTRL_MODE_LSB +: 2];
        c.im   = w[CTRL_IM_BIT];
        return c;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counter peripheral: CTRL/PRESET/COUNT registers on the
// data-memory bus, one-shot or auto-reload operation, maskable interrupt.
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    tim_state_e  state_q;
    tim_ctrl_t   ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic [1:0]  offset;
    logic        wr_accept;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign offset      = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign wr_accept   = WE && (BE == 4'b1111);
    assign wr_ctrl     = wr_accept && (offset == TIM_CTRL);
    assign wr_preset   = wr_accept && (offset == TIM_PRESET);

    // A CPU write to CTRL or PRESET takes priority over the FSM for the whole
    // cycle, so a write landing in INT leaves EN and the flag as written/cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TIM_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            state_q    <= TIM_IDLE;
            irq_flag_q <= 1'b0;
            if (wr_ctrl) begin
                ctrl_q <= ctrl_from_word(WD);
            end
            if (wr_preset) begin
                preset_q <= WD;
            end
        end else begin
            case (state_q)
                TIM_IDLE: begin
                    if (ctrl_q.en) begin
                        state_q <= TIM_LOAD;
                    end
                end
                TIM_LOAD: begin
                    count_q <= preset_q;
                    state_q <= TIM_CNT;
                end
                TIM_CNT: begin
                    if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q    <= '0;
                        irq_flag_q <= 1'b1;
                        state_q    <= TIM_INT;
                    end
                end
                TIM_INT: begin
                    if (ctrl_q.mode == TIM_MODE_RELOAD) begin
                        irq_flag_q <= 1'b0;
                    end else begin
                        ctrl_q.en <= 1'b0;
                    end
                    state_q <= TIM_IDLE;
                end
                default: state_q <= TIM_IDLE;
            endcase
        end
    end

    always_comb begin
        RD = '0;
        case (offset)
            TIM_CTRL:   RD = ctrl_to_word(ctrl_q);
            TIM_PRESET: RD = preset_q;
            TIM_COUNT:  RD = count_q;
            default:    RD = '0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: table-driven one-shot sequence plus
// hand-written sequences, expectations queued per cycle and checked mid-cycle.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    always #5 clk = ~clk;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WE    (WE),
        .BE    (BE),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [1:0]  off;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    exp_t  sb[$];
    string sb_name[$];
    int    checks = 0;
    int    errors = 0;
    vec_t  tbl[13];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive after the rising edge, check at the falling edge.
    task automatic step(input logic we, input logic [3:0] be, input logic [1:0] off,
                        input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_irq, input string nm);
        exp_t  e;
        string n;
        WE   = we;
        BE   = be;
        addr = 32'h0000_7F10 | {28'd0, off, 2'b00};
        WD   = wd;
        e.chk_rd  = chk_rd;
        e.exp_rd  = exp_rd;
        e.exp_irq = exp_irq;
        sb.push_back(e);
        sb_name.push_back(nm);
        @(negedge clk);
        e = sb.pop_front();
        n = sb_name.pop_front();
        if (e.chk_rd) check32({n, " rd"}, RD, e.exp_rd);
        check32({n, " irq"}, {31'd0, IRQ}, {31'd0, e.exp_irq});
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic irq, input string nm);
        step(1'b1, 4'hF, off, d, 1'b0, 32'd0, irq, nm);
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp, input logic irq, input string nm);
        step(1'b0, 4'hF, off, 32'd0, 1'b1, exp, irq, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Mode 0 one-shot: PRESET=3, CTRL=0x9 captured in row 1 (cycle t).
        tbl[0]  = '{1'b1, 4'hF, 2'd1, 32'd3, 1'b0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 2'd0, 32'h9, 1'b0, 32'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd0, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd0, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd3, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd2, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd1, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd0, 1'b1};
        tbl[8]  = '{1'b0, 4'hF, 2'd0, 32'd0, 1'b1, 32'h8, 1'b1};
        tbl[9]  = '{1'b0, 4'hF, 2'd0, 32'd0, 1'b1, 32'h8, 1'b1};
        tbl[10] = '{1'b1, 4'hF, 2'd0, 32'h8, 1'b0, 32'd0, 1'b1};
        tbl[11] = '{1'b0, 4'hF, 2'd0, 32'd0, 1'b1, 32'h8, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 2'd2, 32'd0, 1'b1, 32'd0, 1'b0};

        reset = 1'b1;
        WE    = 1'b0;
        BE    = 4'h0;
        WD    = '0;
        addr  = 32'h0000_7F00;
        #1 reset = 1'b0;
        #1;
        check32("reset irq", {31'd0, IRQ}, 32'd0);
        check32("reset ctrl", RD, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].be, tbl[i].off, tbl[i].wd, tbl[i].chk_rd,
                 tbl[i].exp_rd, tbl[i].exp_irq, $sformatf("mode0[%0d]", i));
        end

        // Mode 1 auto-reload: PRESET=2 gives an INT cycle every 5 cycles.
        wr(2'd1, 32'd2, 1'b0, "m1 preset");
        wr(2'd0, 32'hB, 1'b0, "m1 ctrl");
        for (int k = 1; k <= 16; k++) begin
            rd(2'd0, 32'hB, (k % 5) == 0, $sformatf("mode1[%0d]", k));
        end
        wr(2'd0, 32'h0, 1'b0, "m1 stop");

        // Zero preset with IM=0: INT at t+4 stays silent, flag cleared by write.
        wr(2'd1, 32'd0, 1'b0, "zp preset");
        wr(2'd0, 32'h1, 1'b0, "zp ctrl");
        rd(2'd2, 32'd0, 1'b0, "zp t+1");
        rd(2'd2, 32'd0, 1'b0, "zp t+2");
        rd(2'd2, 32'd0, 1'b0, "zp t+3");
        rd(2'd0, 32'h1, 1'b0, "zp t+4");
        rd(2'd0, 32'h0, 1'b0, "zp t+5");
        wr(2'd0, 32'h8, 1'b0, "zp im");
        rd(2'd0, 32'h8, 1'b0, "zp after im");

        // Ignored writes: freeze COUNT at 8, then try illegal writes.
        wr(2'd1, 32'd10, 1'b0, "ig preset");
        wr(2'd0, 32'h1, 1'b0, "ig ctrl");
        rd(2'd2, 32'd0, 1'b0, "ig t+1");
        rd(2'd2, 32'd0, 1'b0, "ig t+2");
        rd(2'd2, 32'd10, 1'b0, "ig t+3");
        rd(2'd2, 32'd9, 1'b0, "ig t+4");
        wr(2'd0, 32'h0, 1'b0, "ig stop");
        rd(2'd2, 32'd8, 1'b0, "ig frozen");
        wr(2'd2, 32'hFFFF, 1'b0, "ig count wr");
        rd(2'd2, 32'd8, 1'b0, "ig count kept");
        step(1'b1, 4'b0011, 2'd1, 32'h1234, 1'b0, 32'd0, 1'b0, "ig be0011");
        rd(2'd1, 32'd10, 1'b0, "ig preset kept");
        step(1'b0, 4'hF, 2'd1, 32'h5555, 1'b0, 32'd0, 1'b0, "ig we0");
        rd(2'd1, 32'd10, 1'b0, "ig preset kept2");
        wr(2'd3, 32'hFFFF_FFFF, 1'b0, "ig off3 wr");
        rd(2'd3, 32'd0, 1'b0, "ig off3");
        step(1'b1, 4'b0111, 2'd0, 32'hF, 1'b0, 32'd0, 1'b0, "ig ctrl be");
        rd(2'd0, 32'd0, 1'b0, "ig ctrl kept");

        // Collision: PRESET write in the INT cycle wins and counting restarts.
        wr(2'd1, 32'd2, 1'b0, "col preset");
        wr(2'd0, 32'h9, 1'b0, "col ctrl");
        rd(2'd2, 32'd8, 1'b0, "col t+1");
        rd(2'd2, 32'd8, 1'b0, "col t+2");
        rd(2'd2, 32'd2, 1'b0, "col t+3");
        rd(2'd2, 32'd1, 1'b0, "col t+4");
        wr(2'd1, 32'd7, 1'b1, "col int wr");
        rd(2'd0, 32'h9, 1'b0, "col t+6");
        rd(2'd2, 32'd0, 1'b0, "col t+7");
        rd(2'd2, 32'd7, 1'b0, "col t+8");
        rd(2'd2, 32'd6, 1'b0, "col t+9");

        // Reset mid-count with PRESET=5, EN=1.
        wr(2'd1, 32'd5, 1'b0, "rst preset");
        wr(2'd0, 32'h9, 1'b0, "rst ctrl");
        rd(2'd2, 32'd5, 1'b0, "rst t+1");
        rd(2'd2, 32'd5, 1'b0, "rst t+2");
        rd(2'd2, 32'd5, 1'b0, "rst t+3");
        rd(2'd2, 32'd4, 1'b0, "rst t+4");
        WE = 1'b0;
        #1 reset = 1'b0;
        #1;
        check32("async irq", {31'd0, IRQ}, 32'd0);
        for (int o = 0; o < 4; o++) begin
            addr = 32'h0000_7F10 | (o << 2);
            #1;
            check32($sformatf("async rd%0d", o), RD, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd0, 32'd0, 1'b0, "post rst ctrl");
        rd(2'd2, 32'd0, 1'b0, "post rst count");
        rd(2'd2, 32'd0, 1'b0, "post rst idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
